emotion_sel_ctrl: RTL and testbench



---
 rtl/emotion_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/emotion_sel_ctrl.sv | 123 ++++++++++++
 tb/tb_emotion_sel_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/emotion_pkg.sv
// Shared emotion select encoding and commit-FSM state type.
// Used by the select controller, the colour mux and the emoji ROM selectors.
// No logic here; constants, types and a modulo-4 step helper only.
package emotion_pkg;

  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] EMO_HAPPY = 2'b00;
  localparam logic [SEL_W-1:0] EMO_SAD   = 2'b01;
  localparam logic [SEL_W-1:0] EMO_MAD   = 2'b10;
  localparam logic [SEL_W-1:0] EMO_CRAZY = 2'b11;

  // IDLE: pending target equals the committed select; PEND: they differ.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } commit_state_t;

  // Step a select one place forward or back; natural 2-bit wrap gives modulo 4.
  function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] s, input logic up);
    return up ? (s + 2'd1) : (s - 2'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchroniser, stability counter, rising-edge pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES from a clean press to the rise pulse.
// No backpressure; rise is a single-cycle pulse per accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser for the raw asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Count consecutive cycles where the synchronised level disagrees with the
  // accepted level; any return to agreement restarts the count from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pulse in the cycle the accepted level is about to flip from 0 to 1.
  assign rise = sync2 && !level && (cnt == CNT_LAST);

endmodule

// File: rtl/emotion_sel_ctrl.sv
// Emotion select controller: buttons/auto-timer move a pending target, committed at frame start.
// Latency: request to o_sel is held until the next i_frame_start, then one clock.
// No backpressure; simultaneous next/prev requests cancel each other.
module emotion_sel_ctrl
  import emotion_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int AUTO_FRAMES     = 120
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_btn_next,
  input  logic             i_btn_prev,
  input  logic             i_auto_en,
  input  logic             i_frame_start,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_sel_changed
);

  localparam logic [15:0] AUTO_LAST = 16'(AUTO_FRAMES - 1);

  logic             next_req;
  logic             prev_req;
  logic             manual_req;
  logic             auto_sync1;
  logic             auto_on;
  logic             auto_fire;
  logic [15:0]      frame_cnt;
  logic             step_up;
  logic             step_dn;
  logic [SEL_W-1:0] target;
  logic [SEL_W-1:0] target_nxt;
  logic [SEL_W-1:0] sel;
  logic             sel_changed;
  logic             commit;
  commit_state_t    state;
  commit_state_t    state_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .btn   (i_btn_next),
    .rise  (next_req)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .btn   (i_btn_prev),
    .rise  (prev_req)
  );

  assign manual_req = next_req || prev_req;

  // The auto switch is a slow level; synchronising it is enough.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      auto_sync1 <= 1'b0;
      auto_on    <= 1'b0;
    end else begin
      auto_sync1 <= i_auto_en;
      auto_on    <= auto_sync1;
    end
  end

  // Auto advance fires on the frame pulse that would bring the count to AUTO_FRAMES.
  assign auto_fire = auto_on && i_frame_start && (frame_cnt == AUTO_LAST);

  // Frame counter: held at zero when auto is off, restarted by any manual request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt <= '0;
    end else if (!auto_on || manual_req || auto_fire) begin
      frame_cnt <= '0;
    end else if (i_frame_start) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Next target and commit decision; same-cycle requests join a frame-start commit.
  always_comb begin
    step_up    = next_req || auto_fire;
    step_dn    = prev_req;
    target_nxt = target;
    state_nxt  = state;
    commit     = 1'b0;

    if (step_up && !step_dn) begin
      target_nxt = sel_step(target, 1'b1);
    end else if (step_dn && !step_up) begin
      target_nxt = sel_step(target, 1'b0);
    end

    case (state)
      ST_IDLE: if (target_nxt != sel) state_nxt = ST_PEND;
      ST_PEND: if (target_nxt == sel) state_nxt = ST_IDLE;
    endcase

    if (i_frame_start && (state_nxt == ST_PEND)) begin
      commit    = 1'b1;
      state_nxt = ST_IDLE;
    end
  end

  // State, pending target and committed select registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      target      <= EMO_HAPPY;
      sel         <= EMO_HAPPY;
      sel_changed <= 1'b0;
    end else begin
      state       <= state_nxt;
      target      <= target_nxt;
      sel_changed <= commit;
      if (commit) sel <= target_nxt;
    end
  end

  assign o_sel         = sel;
  assign o_sel_changed = sel_changed;

endmodule

// File: tb/tb_emotion_sel_ctrl.sv
// Scoreboard bench for emotion_sel_ctrl with DEBOUNCE_CYCLES=4, AUTO_FRAMES=3.
// The reference model works at the request level: a long press is one step, a frame commits.
// Expected commits are queued at frame issue and checked by an independent monitor.
module tb_emotion_sel_ctrl;

  localparam int DEB  = 4;
  localparam int AUTO = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       auto_en = 1'b0;
  logic       frame_start = 1'b0;
  logic [1:0] o_sel;
  logic       o_sel_changed;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int sel;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state.
  int m_target = 0;
  int m_sel = 0;
  int m_fcnt = 0;
  bit m_auto = 0;

  logic [1:0] prev_sel = 2'b00;

  emotion_sel_ctrl #(.DEBOUNCE_CYCLES(DEB), .AUTO_FRAMES(AUTO)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_btn_next    (btn_next),
    .i_btn_prev    (btn_prev),
    .i_auto_en     (auto_en),
    .i_frame_start (frame_start),
    .o_sel         (o_sel),
    .o_sel_changed (o_sel_changed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change pulse must match the next queued commit, and o_sel
  // must never move without one.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sel = 2'b00;
    end else begin
      total++;
      if (o_sel_changed) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_commit: o_sel=%0d pulse at cycle %0d, no commit expected", o_sel, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (int'(o_sel) != e.sel || cyc != e.cyc) begin
            bad++;
            $display("FAIL commit: got sel=%0d at cycle %0d, want sel=%0d at cycle %0d",
                     o_sel, cyc, e.sel, e.cyc);
          end
        end
      end else if (o_sel !== prev_sel) begin
        bad++;
        $display("FAIL silent_change: o_sel %0d -> %0d without pulse", prev_sel, o_sel);
      end
      prev_sel = o_sel;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk_sel(input string name);
    total++;
    if (int'(o_sel) != m_sel || o_sel_changed !== 1'b0) begin
      bad++;
      $display("FAIL %s: o_sel=%0d changed=%0b, want o_sel=%0d changed=0", name, o_sel, o_sel_changed, m_sel);
    end
  endtask

  task automatic model_reset();
    m_target = 0;
    m_sel = 0;
    m_fcnt = 0;
    m_auto = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    auto_en = 1'b0;
    frame_start = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Hold the buttons for len cycles, release, and let both edges settle.
  task automatic press(input bit n, input bit p, input int len);
    @(negedge clk);
    btn_next = n;
    btn_prev = p;
    repeat (len) @(negedge clk);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (12) @(negedge clk);
    if (len >= DEB + 6 && (n || p)) begin
      if (n && !p) m_target = (m_target + 1) % 4;
      else if (p && !n) m_target = (m_target + 3) % 4;
      m_fcnt = 0;
    end
  endtask

  task automatic set_auto(input bit v);
    @(negedge clk);
    auto_en = v;
    repeat (4) @(negedge clk);
    m_auto = v;
    if (!v) m_fcnt = 0;
  endtask

  // One frame-start pulse followed by the rest of a 20-cycle frame.
  task automatic frame();
    exp_t e;
    @(negedge clk);
    if (m_auto) begin
      m_fcnt++;
      if (m_fcnt == AUTO) begin
        m_fcnt = 0;
        m_target = (m_target + 1) % 4;
      end
    end
    if (m_target != m_sel) begin
      m_sel = m_target;
      e.sel = m_sel;
      e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (18) @(negedge clk);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_sel("reset_state");

    // 1: idle frames produce nothing.
    repeat (5) frame();
    chk_sel("idle_frames");

    // 2: clean next press, committed only at frame.
    press(1, 0, 10);
    chk_sel("no_change_before_frame");
    frame();
    chk_sel("next_commit");

    // 3: bounce too short, then back to 00 and wrap via prev.
    press(1, 0, 2);
    frame();
    chk_sel("short_press_ignored");
    press(0, 1, 10);
    frame();
    chk_sel("prev_to_happy");
    press(0, 1, 10);
    frame();
    chk_sel("prev_wrap");

    // 4: accumulation and simultaneous cancel.
    press(1, 0, 10);
    press(1, 0, 10);
    chk_sel("accumulate_pending");
    frame();
    chk_sel("accumulate_commit");
    press(1, 1, 10);
    frame();
    chk_sel("both_cancel");

    // 5: auto cycling, with a manual request restarting the frame count.
    set_auto(1);
    repeat (8) frame();
    chk_sel("auto_cycle");
    frame();
    press(1, 0, 10);
    repeat (4) frame();
    chk_sel("auto_restart");
    set_auto(0);

    // Randomised mix of presses, bounces, frames and auto toggling.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 6))
        0, 1: press(1, 0, $urandom_range(10, 14));
        2:    press(0, 1, $urandom_range(10, 14));
        3:    press($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(1, 2));
        4:    press(1, 1, 10);
        5:    set_auto(!m_auto);
        default: frame();
      endcase
      if ($urandom_range(0, 2) == 0) frame();
    end
    set_auto(0);
    frame();
    chk_sel("random_end");

    // 6: asynchronous reset with a request pending.
    do_reset();
    press(1, 0, 10);
    press(1, 0, 10);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (o_sel !== 2'b00 || o_sel_changed !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: o_sel=%0d changed=%0b, want o_sel=0 changed=0", o_sel, o_sel_changed);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame();
    chk_sel("reset_discards_pending");

    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_commits: %0d expected commits never seen, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
